// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC, mispredict redirect and optional BTB prediction.
// Define FETCH_BTB_EN to build the 16-entry BTB and predicted-taken redirect path.
module fetch_unit (
    input  logic        CLK,
    input  logic        NRST,
    input  logic        stall,
    input  logic        fail_predict,
    input  logic [12:0] redirect_pc,
    input  logic        upd_valid,
    input  logic [12:0] upd_pc,
    input  logic [12:0] upd_target,
    input  logic        upd_taken,
    output logic [10:0] imem_addr,
    output logic        imem_en,
    input  logic [31:0] imem_rdata,
    output logic [12:0] pcF,
    output logic [31:0] instF,
    output logic        hit_predict1
);

    logic [12:0] pc_q;
    logic [12:0] pcf_q;
    logic        kill_q;
    logic        redirect_take;
    logic [12:0] redirect_target;

    assign imem_addr = pc_q[12:2];
    assign imem_en   = ~stall | fail_predict;
    assign pcF       = pcf_q;
    // kill_q blanks instF until the first fetch after reset or a mispredict returns
    assign instF     = kill_q ? 32'h0 : imem_rdata;

    always_ff @(posedge CLK) begin
        if (!NRST) begin
            pc_q   <= 13'h0;
            pcf_q  <= 13'h0;
            kill_q <= 1'b1;
        end else if (fail_predict) begin
            pc_q   <= redirect_pc;
            pcf_q  <= 13'h0;
            kill_q <= 1'b1;
        end else if (!stall) begin
            pcf_q  <= pc_q;
            kill_q <= 1'b0;
            pc_q   <= redirect_take ? redirect_target : pc_q + 13'd4;
        end
    end

`ifdef FETCH_BTB_EN
    logic [15:0]       btb_valid;
    logic [15:0][6:0]  btb_tag;
    logic [15:0][12:0] btb_target;
    logic [15:0][1:0]  btb_ctr;
    logic [3:0]        look_idx;
    logic              look_taken;
    logic [3:0]        upd_idx;
    logic              upd_hit;
    logic              pend_taken_q;
    logic [12:0]       pend_target_q;
    logic              hit_q;
    logic              unused_upd_bits;

    assign unused_upd_bits = ^upd_pc[1:0];

    assign look_idx   = pc_q[5:2];
    assign look_taken = btb_valid[look_idx] && (btb_tag[look_idx] == pc_q[12:6])
                        && btb_ctr[look_idx][1];

    assign redirect_take   = pend_taken_q;
    assign redirect_target = pend_target_q;
    assign hit_predict1    = hit_q;

    // No new prediction while the previous one's redirect is being applied
    always_ff @(posedge CLK) begin
        if (!NRST) begin
            pend_taken_q  <= 1'b0;
            pend_target_q <= 13'h0;
            hit_q         <= 1'b0;
        end else if (fail_predict) begin
            pend_taken_q  <= 1'b0;
            pend_target_q <= 13'h0;
            hit_q         <= 1'b0;
        end else if (!stall) begin
            pend_taken_q  <= look_taken & ~pend_taken_q;
            pend_target_q <= btb_target[look_idx];
            hit_q         <= pend_taken_q;
        end
    end

    assign upd_idx = upd_pc[5:2];
    assign upd_hit = btb_valid[upd_idx] && (btb_tag[upd_idx] == upd_pc[12:6]);

    // Lookup reads the arrays combinationally, so same-cycle updates are seen only next cycle
    always_ff @(posedge CLK) begin
        if (!NRST) begin
            btb_valid  <= '0;
            btb_tag    <= '0;
            btb_target <= '0;
            btb_ctr    <= {16{2'b01}};
        end else if (upd_valid) begin
            if (upd_hit) begin
                if (upd_taken) begin
                    btb_target[upd_idx] <= upd_target;
                    if (btb_ctr[upd_idx] != 2'b11)
                        btb_ctr[upd_idx] <= btb_ctr[upd_idx] + 2'b01;
                end else if (btb_ctr[upd_idx] != 2'b00) begin
                    btb_ctr[upd_idx] <= btb_ctr[upd_idx] - 2'b01;
                end
            end else if (upd_taken) begin
                btb_valid[upd_idx]  <= 1'b1;
                btb_tag[upd_idx]    <= upd_pc[12:6];
                btb_target[upd_idx] <= upd_target;
                btb_ctr[upd_idx]    <= 2'b10;
            end
        end
    end
`else
    logic unused_upd;

    assign unused_upd      = ^{upd_valid, upd_pc, upd_target, upd_taken};
    assign redirect_take   = 1'b0;
    assign redirect_target = 13'h0;
    assign hit_predict1    = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; expectations follow FETCH_BTB_EN when it is defined.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        NRST;
    logic        stall;
    logic        fail_predict;
    logic [12:0] redirect_pc;
    logic        upd_valid;
    logic [12:0] upd_pc;
    logic [12:0] upd_target;
    logic        upd_taken;
    logic [10:0] imem_addr;
    logic        imem_en;
    logic [31:0] imem_rdata = 32'h0;
    logic [12:0] pcF;
    logic [31:0] instF;
    logic        hit_predict1;

    int checks = 0;
    int passed = 0;

    fetch_unit dut (
        .CLK(CLK), .NRST(NRST), .stall(stall), .fail_predict(fail_predict),
        .redirect_pc(redirect_pc), .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_target(upd_target), .upd_taken(upd_taken), .imem_addr(imem_addr),
        .imem_en(imem_en), .imem_rdata(imem_rdata), .pcF(pcF), .instF(instF),
        .hit_predict1(hit_predict1)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] dat(input logic [10:0] a);
        return 32'hC0DE_0000 | {21'h0, a};
    endfunction

    always @(posedge CLK) if (imem_en) imem_rdata <= dat(imem_addr);

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_pc(input string nm, input logic [12:0] exp);
        checks++;
        if (pcF !== exp) $display("FAIL %s pcF got %h want %h", nm, pcF, exp);
        else passed++;
    endtask

    task automatic chk_addr(input string nm, input logic [10:0] exp);
        checks++;
        if (imem_addr !== exp) $display("FAIL %s imem_addr got %h want %h", nm, imem_addr, exp);
        else passed++;
    endtask

    task automatic chk_inst(input string nm, input logic [31:0] exp);
        checks++;
        if (instF !== exp) $display("FAIL %s instF got %h want %h", nm, instF, exp);
        else passed++;
    endtask

    task automatic chk_hit(input string nm, input logic exp);
        checks++;
        if (hit_predict1 !== exp) $display("FAIL %s hit_predict1 got %b want %b", nm, hit_predict1, exp);
        else passed++;
    endtask

    task automatic redirect(input logic [12:0] pc);
        fail_predict = 1'b1;
        redirect_pc  = pc;
        tick();
        fail_predict = 1'b0;
    endtask

    task automatic test_reset();
        NRST = 1'b0; stall = 1'b0; fail_predict = 1'b0; redirect_pc = 13'h0;
        upd_valid = 1'b0; upd_pc = 13'h0; upd_target = 13'h0; upd_taken = 1'b0;
        tick(); tick();
        chk_pc("rst", 13'h0);
        chk_inst("rst", 32'h0);
        chk_hit("rst", 1'b0);
        chk_addr("rst", 11'h0);
        NRST = 1'b1;
    endtask

    task automatic test_sequential();
        chk_addr("seq0", 11'h0);
        checks++;
        if (imem_en !== 1'b1) $display("FAIL seq0 imem_en got %b want 1", imem_en);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_pc("seq", 13'(4 * i));
            chk_inst("seq", dat(11'(i)));
            chk_addr("seq", 11'(i + 1));
            chk_hit("seq", 1'b0);
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_pc("stall", 13'h8);
            chk_inst("stall", dat(11'h2));
            chk_addr("stall", 11'h3);
            checks++;
            if (imem_en !== 1'b0) $display("FAIL stall imem_en got %b want 0", imem_en);
            else passed++;
        end
        stall = 1'b0;
        tick();
        chk_pc("resume", 13'hC);
        chk_inst("resume", dat(11'h3));
        chk_addr("resume", 11'h4);
    endtask

    task automatic test_mispredict();
        stall = 1'b1;
        fail_predict = 1'b1;
        redirect_pc = 13'h100;
        #1;
        checks++;
        if (imem_en !== 1'b1) $display("FAIL mp imem_en got %b want 1", imem_en);
        else passed++;
        tick();
        fail_predict = 1'b0;
        stall = 1'b0;
        chk_pc("mp_kill", 13'h0);
        chk_inst("mp_kill", 32'h0);
        chk_addr("mp_kill", 11'h40);
        tick();
        chk_pc("mp_new", 13'h100);
        chk_inst("mp_new", dat(11'h40));
        chk_addr("mp_new", 11'h41);
    endtask

    task automatic test_wrap();
        redirect(13'h1FFC);
        tick();
        chk_pc("wrap", 13'h1FFC);
        chk_addr("wrap", 11'h0);
        tick();
        chk_pc("wrap2", 13'h0);
    endtask

    task automatic test_btb_taken();
        // allocation while stalled must still take effect
        stall = 1'b1;
        upd_valid = 1'b1; upd_pc = 13'h20; upd_target = 13'h80; upd_taken = 1'b1;
        tick();
        upd_valid = 1'b0;
        stall = 1'b0;
        redirect(13'h20);
        chk_pc("bt_kill", 13'h0);
        tick();
        chk_pc("bt_br", 13'h20);
        chk_inst("bt_br", dat(11'h8));
        chk_hit("bt_br", 1'b0);
        tick();
        chk_pc("bt_slot", 13'h24);
`ifdef FETCH_BTB_EN
        chk_hit("bt_slot", 1'b1);
        chk_addr("bt_slot", 11'h20);
        tick();
        chk_pc("bt_tgt", 13'h80);
        chk_inst("bt_tgt", dat(11'h20));
        chk_hit("bt_tgt", 1'b0);
`else
        chk_hit("bt_slot", 1'b0);
        chk_addr("bt_slot", 11'hA);
        tick();
        chk_pc("bt_seq", 13'h28);
        chk_hit("bt_seq", 1'b0);
`endif
    endtask

    task automatic test_btb_not_taken();
        // three not-taken: 10 -> 01 -> 00 -> 00 (a wrapping counter would read 11)
        upd_valid = 1'b1; upd_pc = 13'h20; upd_target = 13'h80; upd_taken = 1'b0;
        tick(); tick(); tick();
        upd_valid = 1'b0;
        redirect(13'h20);
        tick();
        chk_pc("nt_br", 13'h20);
        tick();
        chk_pc("nt_seq1", 13'h24);
        chk_hit("nt_seq1", 1'b0);
        tick();
        chk_pc("nt_seq2", 13'h28);
        chk_hit("nt_seq2", 1'b0);
    endtask

    task automatic test_reset_mid();
        upd_valid = 1'b1; upd_pc = 13'h20; upd_target = 13'h80; upd_taken = 1'b1;
        tick(); tick();
        upd_valid = 1'b0;
        redirect(13'h20);
        tick();
        NRST = 1'b0;
        tick();
        chk_pc("mrst", 13'h0);
        chk_inst("mrst", 32'h0);
        chk_hit("mrst", 1'b0);
        chk_addr("mrst", 11'h0);
        NRST = 1'b1;
        // BTB was cleared, so refetching 0x20 must be sequential
        redirect(13'h20);
        tick(); tick();
        chk_pc("mrst_seq", 13'h24);
        chk_hit("mrst_seq", 1'b0);
        tick();
        chk_pc("mrst_seq2", 13'h28);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_mispredict();
        test_wrap();
        test_btb_taken();
        test_btb_not_taken();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL provide port CLK  input  1  rising-edge clock.
REQ-002 SHALL provide port NRST  input  1  reset, synchronous, active-low.
REQ-003 SHALL provide ports stall  input  1  hold fetch; fail_predict  input  1  execute-stage mispredict; redirect_pc  input  13  correct PC on mispredict.
REQ-004 SHALL provide ports upd_valid  input  1  resolved branch; upd_pc  input  13  its PC; upd_target  input  13  its target; upd_taken  input  1  resolved direction.
REQ-005 SHALL provide ports imem_addr  output  11  word address; imem_en  output  1  read enable; imem_rdata  input  32  data, one-cycle latency, held when imem_en=0.
REQ-006 SHALL provide ports pcF  output  13  PC of instF; instF  output  32  fetched instruction; hit_predict1  output  1  current instF is a wrong-path slot.

Function
REQ-007 SHALL keep internal PC pc_q and drive imem_addr=pc_q[12:2] and imem_en=~stall | fail_predict.
REQ-008 SHALL present instF=imem_rdata and pcF=PC issued in the previous enabled cycle, one cycle after issue.
REQ-009 SHALL, with stall=1 and fail_predict=0, hold pc_q, pcF, instF, hit_predict1 and all pending-prediction state.
REQ-010 SHALL, with fail_predict=1, load pc_q<=redirect_pc, drive instF=0 and pcF=0 the next cycle, clear pending prediction and hit_predict1; this has priority over stall and prediction.
REQ-011 SHALL otherwise advance pc_q<=pc_q+4, wrapping modulo 2^13.
REQ-012 SHALL contain a 16-entry direct-mapped BTB: index pc[5:2], tag pc[12:6], 13-bit target, 2-bit saturating counter, valid bit.
REQ-013 SHALL look up the BTB at pc_q in each enabled cycle; predicted-taken = valid & tag match & counter[1]; result registered as pending with its target.
REQ-014 SHALL, in the cycle after a predicted-taken lookup (predicted branch on instF), load pc_q<=pending target instead of pc_q+4 if not stalled.
REQ-015 SHALL assert hit_predict1 for the cycle after that, while the sequential instruction fetched at branch+4 is on instF, then deassert on the next unstalled cycle.
REQ-016 SHALL not issue a new prediction in the cycle the redirect of REQ-014 is applied.
REQ-017 SHALL, on upd_valid, update regardless of stall: tag hit -> counter +1 if taken / -1 if not, saturating at 00/11; target written when taken; tag miss and taken -> allocate, valid=1, counter=10; tag miss and not taken -> no change.
REQ-018 SHALL return pre-update contents when lookup and update target the same index in one cycle.

Reset
REQ-019 SHALL, while NRST=0 at a rising edge, set pc_q=0, pcF=0, instF=0, hit_predict1=0, pending cleared, all BTB valid=0 and counters=01.
REQ-020 SHALL issue address 0 in the first cycle after NRST deasserts; reset mid-operation discards all pending state.

Configuration
REQ-021 SHALL, with FETCH_BTB_EN defined, include the BTB and prediction path of REQ-012..REQ-018.
REQ-022 SHALL, without FETCH_BTB_EN, omit the BTB, ignore upd_*, tie hit_predict1=0, and fetch only sequentially or via fail_predict.

Verification
REQ-023 Reset then run: pcF sequence 0,4,8,12 one cycle behind imem_addr 0,1,2,3; hit_predict1=0.
REQ-024 stall=1 for 3 cycles at pcF=8: pcF=8, instF, imem_addr held; resumes with pcF=12.
REQ-025 fail_predict=1, redirect_pc=0x100 while stall=1: next cycle instF=0, pcF=0; following cycle pcF=0x100.
REQ-026 upd_valid taken pc=0x20 target=0x80; refetch 0x20: instF at pcF=0x20, next cycle pcF=0x24 with hit_predict1=1, then pcF=0x80.
REQ-027 Two not-taken updates at 0x20 after allocation: counter 10->01->00; refetch 0x20 sequential, hit_predict1=0; without FETCH_BTB_EN same stimulus of REQ-026 yields no redirect.
